// File: rtl/mips32_pkg.sv
// Shared types and constants for the MIPS32 fetch front end.
package mips32_pkg;

  localparam int unsigned PFQ_AW = 10;
  localparam int unsigned PFQ_DW = 32;

  localparam logic [5:0] OPC_HLT = 6'b111111;

  typedef logic [31:0] instr_t;

  typedef struct packed {
    logic [PFQ_AW-1:0] pc;
    instr_t            instr;
  } fetch_entry_t;

  function automatic logic is_hlt(input instr_t w);
    return w[31:26] == OPC_HLT;
  endfunction

endpackage

// File: rtl/mips32_prefetch_queue_if.sv
// Memory-side and IF-side signals of the prefetch queue; master = queue, slave = environment.
interface mips32_prefetch_queue_if
  import mips32_pkg::*;
#(
  parameter int unsigned AW = PFQ_AW,
  parameter int unsigned DW = PFQ_DW
);

  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          if_valid;
  logic [DW-1:0] if_instr;
  logic [AW-1:0] if_pc;
  logic          if_ready;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          halted;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output if_valid, if_instr, if_pc,
    input  if_ready, redirect, redirect_pc,
    output halted
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  if_valid, if_instr, if_pc,
    output if_ready, redirect, redirect_pc,
    input  halted
  );

endinterface

// File: rtl/pfq_fifo.sv
// Synchronous FIFO of fetch entries with flush; push and pop may coincide even when full.
module pfq_fifo
  import mips32_pkg::*;
#(
  parameter type         T     = fetch_entry_t,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  T                       wdata,
  input  logic                   pop,
  input  logic                   flush,
  output T                       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  T              store [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // When full, a simultaneous push overwrites the slot being popped; the head is read before the edge.
  always_ff @(posedge clk) begin
    if (push && !flush) store[wr_ptr] <= wdata;
  end

  assign rdata = store[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/mips32_prefetch_queue.sv
// Instruction prefetch queue ahead of IF: credit-limited fetch, redirect discard, HLT stop.
// Build option PFQ_BYPASS_EN: a response into an empty queue is presented to IF in the same cycle.
module mips32_prefetch_queue
  import mips32_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = PFQ_AW,
  parameter int unsigned DW    = PFQ_DW
) (
  input  logic                    clk1,
  input  logic                    rst_n,
  mips32_prefetch_queue_if.master bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } entry_t;

  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] fifo_count;
  logic          halted_q;
  logic          fifo_empty;
  logic          fifo_full;
  entry_t        head;
  entry_t        wentry;
  logic          grant;
  logic          accept;
  logic          push;
  logic          pop;
  logic          take_hlt;

  always_comb begin
    bus.mem_req  = rst_n && !halted_q && !bus.redirect && ((fifo_count + outstanding) < DEPTH_C);
    bus.mem_addr = fetch_pc;
    bus.halted   = halted_q;
    grant        = bus.mem_req && bus.mem_gnt;
    accept       = rst_n && bus.mem_rvalid && !bus.redirect && (discard == '0) && !halted_q;
    take_hlt     = accept && is_hlt(instr_t'(bus.mem_rdata));
    pop          = !fifo_empty && bus.if_ready && !bus.redirect;
    push         = accept;
    wentry       = '{pc: resp_pc, instr: bus.mem_rdata};
    bus.if_valid = !fifo_empty;
    bus.if_instr = fifo_empty ? '0 : head.instr;
    bus.if_pc    = fifo_empty ? '0 : head.pc;
`ifdef PFQ_BYPASS_EN
    if (fifo_empty && accept) begin
      bus.if_valid = 1'b1;
      bus.if_instr = bus.mem_rdata;
      bus.if_pc    = resp_pc;
      push         = !bus.if_ready;
    end
`endif
  end

  // No grant can coincide with a redirect, so only the arriving response reduces what is still in flight.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= '0;
      resp_pc     <= '0;
      outstanding <= '0;
      discard     <= '0;
      halted_q    <= 1'b0;
    end else if (bus.redirect) begin
      fetch_pc    <= bus.redirect_pc;
      resp_pc     <= bus.redirect_pc;
      outstanding <= outstanding - CW'(bus.mem_rvalid);
      discard     <= outstanding - CW'(bus.mem_rvalid);
      halted_q    <= 1'b0;
    end else begin
      if (grant) fetch_pc <= fetch_pc + 1'b1;
      outstanding <= outstanding + CW'(grant) - CW'(bus.mem_rvalid);
      if (bus.mem_rvalid && (discard != '0)) discard <= discard - 1'b1;
      if (accept) resp_pc <= resp_pc + 1'b1;
      if (take_hlt) halted_q <= 1'b1;
    end
  end

  pfq_fifo #(
    .T     (entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk1),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wentry),
    .pop   (pop),
    .flush (bus.redirect),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifndef SYNTHESIS
  a_rsp_without_req: assert property (@(posedge clk1) disable iff (!rst_n)
    bus.mem_rvalid |-> (outstanding != '0));
  a_no_overflow: assert property (@(posedge clk1) disable iff (!rst_n)
    !(push && fifo_full && !pop));
`endif

endmodule

// File: tb/tb_mips32_prefetch_queue.sv
// Directed/randomized bench for mips32_prefetch_queue against a stream-level reference model.
module tb_mips32_prefetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 32;
`ifdef PFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk1 = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk1 = ~clk1;

  mips32_prefetch_queue_if #(.AW(AW), .DW(DW)) bus ();

  mips32_prefetch_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk1  (clk1),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [9:0] addr;
    int         due;
  } pend_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem [1024];
  pend_t       pending [$];
  int          cyc = 0;
  logic [9:0]  exp_fetch;
  logic [9:0]  exp_pc;
  logic [9:0]  epoch_pc;
  int          hlt_off;
  bit          done;
  bit          byp_probe;
  int          grants, pops;
  int          gnt_pct = 100, rdy_pct = 100, lat_lo = 1, lat_hi = 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] safe_word();
    logic [31:0] r;
    r = $urandom;
    if (r[31:26] == 6'h3f) r[31] = 1'b0;
    return r;
  endfunction

  // Stream expectation after a redirect/reset: p, p+1, ... up to and including the first HLT word.
  task automatic new_epoch(input logic [9:0] p);
    logic [9:0] a;
    exp_fetch = p;
    exp_pc    = p;
    epoch_pc  = p;
    done      = 1'b0;
    hlt_off   = 2048;
    for (int i = 0; i < 1024; i++) begin
      a = 10'(p + 10'(i));
      if (mem[a][31:26] == 6'h3f) begin
        hlt_off = i;
        break;
      end
    end
  endtask

  task automatic tick(input bit redir, input logic [9:0] rpc);
    logic [9:0] off;
    bit         rv;
    pend_t      pe;
    bus.mem_gnt = ($urandom_range(99) < gnt_pct);
    rv = (pending.size() != 0) && (pending[0].due <= cyc);
    bus.mem_rvalid = rv;
    if (rv) bus.mem_rdata = mem[pending[0].addr];
    else    bus.mem_rdata = $urandom;
    bus.if_ready    = ($urandom_range(99) < rdy_pct);
    bus.redirect    = redir;
    bus.redirect_pc = redir ? rpc : 10'($urandom);
    #1;
    if (redir) check("redirect_blocks_req", bus.mem_req, 0);
    if (byp_probe && rv) begin
      check("first_resp_if_valid", bus.if_valid, BYP);
      byp_probe = 1'b0;
    end
    if (done) check("idle_after_hlt", bus.if_valid, 0);
    if (bus.mem_req && bus.mem_gnt) begin
      grants++;
      check("mem_addr", bus.mem_addr, exp_fetch);
      off = bus.mem_addr - epoch_pc;
      check("req_bound_after_hlt", (int'(off) < hlt_off + int'(DEPTH)), 1);
      pe.addr = bus.mem_addr;
      pe.due  = cyc + int'($urandom_range(lat_hi, lat_lo));
      pending.push_back(pe);
      exp_fetch++;
    end
    if (bus.if_valid && bus.if_ready && !redir && !done) begin
      pops++;
      check("if_pc", bus.if_pc, exp_pc);
      check("if_instr", bus.if_instr, mem[exp_pc]);
      if (mem[exp_pc][31:26] == 6'h3f) done = 1'b1;
      exp_pc++;
    end
    if (rv) void'(pending.pop_front());
    @(posedge clk1);
    cyc++;
    if (redir) new_epoch(rpc);
    @(negedge clk1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = safe_word();
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    bus.if_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    new_epoch(10'd0);

    // Reset values
    #12;
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_if_valid", bus.if_valid, 0);
    check("rst_if_instr", bus.if_instr, 0);
    check("rst_if_pc", bus.if_pc, 0);
    check("rst_halted", bus.halted, 0);
    @(negedge clk1);
    rst_n = 1'b1;

    // First response into an empty queue: same-cycle only with bypass
    byp_probe = 1'b1;
    repeat (4) tick(1'b0, '0);
    check("probe_taken", byp_probe, 0);

    // Fill with IF stalled
    rdy_pct = 0;
    tick(1'b1, 10'd0);
    grants = 0;
    repeat (12) tick(1'b0, '0);
    check("fill_grants", grants, 4);
    check("fill_req_stops", bus.mem_req, 0);
    check("fill_if_valid", bus.if_valid, 1);
    rdy_pct = 100; pops = 0; grants = 0;
    for (int k = 0; k < 40 && (pops < 4 || grants < 1); k++) tick(1'b0, '0);
    check("fill_drain_pops", pops >= 4, 1);
    check("fill_resume", grants >= 1, 1);

    // Streaming, 3-cycle memory latency
    for (int i = 0; i < 64; i++) mem[i] = 32'(i);
    lat_lo = 3; lat_hi = 3;
    tick(1'b1, 10'd0);
    pops = 0;
    repeat (40) tick(1'b0, '0);
    check("stream_throughput", pops >= 24, 1);

    // Redirect with three fetches in flight
    lat_lo = 4; lat_hi = 4;
    tick(1'b1, 10'd0);
    for (int k = 0; k < 20 && pending.size() < 3; k++) tick(1'b0, '0);
    check("three_in_flight", pending.size(), 3);
    tick(1'b1, 10'h100);
    pops = 0;
    for (int k = 0; k < 60 && pops < 10; k++) tick(1'b0, '0);
    check("redirect_pops", pops, 10);

    // HLT at address 2
    mem[2] = 32'hFC000000;
    gnt_pct = 70; lat_lo = 1; lat_hi = 4;
    tick(1'b1, 10'd0);
    pops = 0;
    repeat (40) tick(1'b0, '0);
    check("hlt_pops", pops, 3);
    check("hlt_halted", bus.halted, 1);
    check("hlt_no_req", bus.mem_req, 0);

    // Redirect clears halted and restarts; then async reset mid-burst while halted
    gnt_pct = 100; rdy_pct = 0; lat_lo = 3; lat_hi = 3;
    tick(1'b1, 10'd0);
    check("restart_unhalted", bus.halted, 0);
    repeat (6) tick(1'b0, '0);
    check("rehalt", bus.halted, 1);
    check("rehalt_if_valid", bus.if_valid, 1);
    #3;
    rst_n = 1'b0;
    bus.mem_rvalid = 1'b0;
    #1;
    check("arst_if_valid", bus.if_valid, 0);
    check("arst_mem_req", bus.mem_req, 0);
    check("arst_halted", bus.halted, 0);
    check("arst_mem_addr", bus.mem_addr, 0);
    pending.delete();
    @(negedge clk1);
    mem[2] = safe_word();
    new_epoch(10'd0);
    rst_n = 1'b1;
    rdy_pct = 100; lat_lo = 1; lat_hi = 1; pops = 0;
    for (int k = 0; k < 40 && pops < 8; k++) tick(1'b0, '0);
    check("post_reset_pops", pops, 8);

    // Address wrap
    lat_hi = 2;
    tick(1'b1, 10'd1022);
    pops = 0;
    for (int k = 0; k < 40 && pops < 6; k++) tick(1'b0, '0);
    check("wrap_pops", pops, 6);

    // Random soak with occasional redirects
    gnt_pct = 60; rdy_pct = 60; lat_lo = 1; lat_hi = 5; pops = 0;
    for (int k = 0; k < 400; k++) tick($urandom_range(39) == 0, 10'($urandom));
    check("soak_progress", pops > 50, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
